// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM stage.
// Imported by mem_stage and dmem_array.
package mem_stage_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are never reset.
module dmem_array
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Commit a store on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // The read port sees the old word, so read-before-write holds.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM stage with wait-state FSM, branch resolution and MEM/WB register.
// Optional macro MISALIGN_TRAP_EN traps misaligned loads/stores.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] reg2_in,
    input  logic [31:0] pc_branch_in,
    input  logic [4:0]  rd_in,
    input  logic        zero_in,
    input  logic        branch_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                req;
    logic                mis;
    logic                stall_w;
    logic                we;
    logic [AW-1:0]       idx;
    logic [WORD_W-1:0]   rdata;

    logic [WORD_W-1:0]     rdata_d, rdata_q;
    logic [WORD_W-1:0]     alu_d, alu_q;
    logic [REG_ADDR_W-1:0] rd_d, rd_q;
    logic                  rw_d, rw_q;
    logic                  m2r_d, m2r_q;
    logic                  mis_d, mis_q;

    assign req = mem_read_in | mem_write_in;
    assign idx = alu_result_in[AW+1:2];

`ifdef MISALIGN_TRAP_EN
    assign mis = req & (alu_result_in[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // Reset kills an in-flight access immediately, hence the gate.
    assign stall_w = !reset && (
        (state_q == IDLE && req && !mis && WAIT_STATES != 0) ||
        (state_q == BUSY && cnt_q != '0));

    assign we = !reset && !stall_w && mem_write_in && !mis;

    assign stall     = stall_w;
    assign pc_src    = branch_in & zero_in;
    assign pc_target = pc_branch_in;

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_dmem (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (idx),
        .wdata_i (reg2_in),
        .rdata_o (rdata)
    );

    // Wait-state sequencer: count down the extra cycles of an access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !mis && WAIT_STATES != 0) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_W'(WAIT_STATES - 1);
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Next MEM/WB contents: bubble while stalled, else capture.
    always_comb begin
        rdata_d = '0;
        alu_d   = '0;
        rd_d    = '0;
        rw_d    = 1'b0;
        m2r_d   = 1'b0;
        mis_d   = 1'b0;
        if (!stall_w) begin
            alu_d   = alu_result_in;
            rd_d    = rd_in;
            rw_d    = reg_write_in & !mis;
            m2r_d   = mem_to_reg_in;
            rdata_d = (mem_read_in && !mis) ? rdata : '0;
            mis_d   = mis;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            mis_q   <= mis_d;
        end
    end

    assign read_data_out  = rdata_q;
    assign alu_result_out = alu_q;
    assign rd_out         = rd_q;
    assign reg_write_out  = rw_q;
    assign mem_to_reg_out = m2r_q;

`ifdef MISALIGN_TRAP_EN
    assign misalign_err = mis_q;
    logic unused_bits;
    assign unused_bits = ^alu_result_in[WORD_W-1:AW+2];
`else
    assign misalign_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{alu_result_in[WORD_W-1:AW+2],
                           alu_result_in[1:0], mis_q};
`endif

endmodule
